// File: rtl/video_timing_pkg.sv
// Shared video timing constants and lock FSM encoding for the hvsync generator/decoder pair.
package video_timing_pkg;

    localparam int unsigned H_DISPLAY    = 256;
    localparam int unsigned H_TOTAL      = 309;
    localparam int unsigned V_DISPLAY    = 240;
    localparam int unsigned V_TOTAL      = 262;
    localparam int unsigned SYNC_TIMEOUT = 2 * H_TOTAL;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StTrack  = 2'd1,
        StLocked = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_period_timer.sv
// Rising-edge detector plus period measurement and loss-of-sync timeout for one sync input.
module sync_period_timer #(
    parameter int unsigned TOTAL   = video_timing_pkg::H_TOTAL,
    parameter int unsigned TIMEOUT = video_timing_pkg::SYNC_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    output logic       rise,
    output logic [9:0] period,
    output logic       period_ok,
    output logic       timeout
);

    logic       sync_q;
    logic       valid_q, valid_d;
    logic [9:0] cnt_q, cnt_d;

    assign rise      = sync & ~sync_q;
    assign period    = cnt_q + 10'd1;
    assign timeout   = ~rise & (cnt_q == 10'(TIMEOUT));
    // The first edge after reset/timeout has no reference, so it is never judged.
    assign period_ok = rise & valid_q & (period == 10'(TOTAL));

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 10'd1;
        end
        if (timeout) begin
            valid_d = 1'b0;
        end else if (rise) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 1'b1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/hvsync_decoder.sv
// Recovers beam position from raw hsync/vsync and qualifies lock against the nominal line period.
module hvsync_decoder #(
    parameter int unsigned H_DISPLAY  = video_timing_pkg::H_DISPLAY,
    parameter int unsigned H_TOTAL    = video_timing_pkg::H_TOTAL,
    parameter int unsigned V_DISPLAY  = video_timing_pkg::V_DISPLAY,
    parameter int unsigned V_TOTAL    = video_timing_pkg::V_TOTAL,
    parameter int unsigned HS_LOAD    = 264,
    parameter int unsigned VS_LOAD    = 254,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);
    import video_timing_pkg::*;

    localparam int unsigned GoodW = $clog2(LOCK_LINES + 1);

    logic             hs_rise, hs_period_ok, hs_timeout;
    logic [9:0]       hs_period;
    logic             vs_q, vs_rise;
    logic             h_wrap;
    logic [8:0]       hpos_q, hpos_d, vpos_q, vpos_d, vpos_free;
    lock_state_e      state_q, state_d;
    logic [GoodW-1:0] good_q, good_d;
    logic             locked_d, err_d;
    logic             display_on_q, locked_q, frame_start_q, sync_err_q;

    sync_period_timer #(
        .TOTAL  (H_TOTAL),
        .TIMEOUT(2 * H_TOTAL)
    ) u_hs_timer (
        .clk      (clk),
        .reset    (reset),
        .sync     (hsync),
        .rise     (hs_rise),
        .period   (hs_period),
        .period_ok(hs_period_ok),
        .timeout  (hs_timeout)
    );

    assign vs_rise = vsync & ~vs_q;
    assign h_wrap  = (hpos_q == 9'(H_TOTAL - 1));

    always_comb begin
        vpos_free = vpos_q;
        if (h_wrap) begin
            vpos_free = (vpos_q == 9'(V_TOTAL - 1)) ? 9'd0 : vpos_q + 9'd1;
        end
        hpos_d = hs_rise ? 9'(HS_LOAD) : (h_wrap ? 9'd0 : hpos_q + 9'd1);
        vpos_d = vs_rise ? 9'(VS_LOAD) : vpos_free;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (hs_timeout) begin
            state_d = StSearch;
            good_d  = '0;
            err_d   = (state_q == StLocked);
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (hs_period_ok) begin
                        state_d = StTrack;
                        good_d  = GoodW'(1);
                    end
                end
                StTrack: begin
                    if (hs_period_ok) begin
                        if (good_q < GoodW'(LOCK_LINES)) good_d = good_q + GoodW'(1);
                    end else if (hs_rise) begin
                        state_d = StSearch;
                        good_d  = '0;
                    end
                    // Lock is judged on the line count already updated by this cycle's hsync.
                    if (vs_rise && state_d == StTrack && good_d >= GoodW'(LOCK_LINES)) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    if ((hs_rise && hs_period != 10'(H_TOTAL)) ||
                        (vs_rise && vpos_free != 9'(VS_LOAD))) begin
                        state_d = StSearch;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = StSearch;
                    good_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_q          <= 1'b1;
            hpos_q        <= '0;
            vpos_q        <= '0;
            state_q       <= StSearch;
            good_q        <= '0;
            display_on_q  <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            vs_q          <= vsync;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            state_q       <= state_d;
            good_q        <= good_d;
            display_on_q  <= locked_d && (hpos_d < 9'(H_DISPLAY)) && (vpos_d < 9'(V_DISPLAY));
            locked_q      <= locked_d;
            frame_start_q <= locked_d && (hpos_d == 9'd0) && (vpos_d == 9'd0);
            sync_err_q    <= err_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign display_on  = display_on_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Drives the decoder from a behavioural sync source with injected faults and checks every output.
module tb_hvsync_decoder;
    import video_timing_pkg::*;

    logic       clk = 1'b0;
    logic       reset, hsync, vsync;
    logic [8:0] hpos, vpos;
    logic       display_on, locked, frame_start, sync_err;

    always #5 clk = ~clk;

    hvsync_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .locked     (locked),
        .frame_start(frame_start),
        .sync_err   (sync_err)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model state: positions, time since last hsync edge, lock stage.
    int m_h, m_v, m_since, m_valid, m_st, m_good, m_hs_prev, m_vs_prev;
    int m_locked, m_disp, m_fs, m_err;

    // Sync source: position counters plus registered sync outputs.
    int src_h, src_v, cur_len, exp_h, exp_v, hold_left;
    bit hs_reg, vs_reg, rst_n_ctl, hold, inj, aligned;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic hs, input logic vs);
        int nh, nv, free_v, nst, ng;
        bit hr, vr, err;
        if (!rn) begin
            m_h = 0; m_v = 0; m_since = 0; m_valid = 0; m_st = 0; m_good = 0;
            m_hs_prev = 1; m_vs_prev = 1;
            m_locked = 0; m_disp = 0; m_fs = 0; m_err = 0;
            return;
        end
        hr = hs && !m_hs_prev;
        vr = vs && !m_vs_prev;
        free_v = (m_h == H_TOTAL - 1) ? (m_v + 1) % V_TOTAL : m_v;
        nh = hr ? 264 : (m_h + 1) % H_TOTAL;
        nv = vr ? 254 : free_v;
        nst = m_st; ng = m_good; err = 0;
        if (!hr && m_since == 2 * H_TOTAL) begin
            nst = 0; ng = 0; m_valid = 0; err = (m_st == 2);
        end else if (hr) begin
            if (!m_valid) begin
                m_valid = 1;
            end else if (m_since + 1 == H_TOTAL) begin
                if (m_st == 0) begin nst = 1; ng = 1; end
                else if (m_st == 1 && m_good < 4) ng = m_good + 1;
            end else if (m_st != 0) begin
                err = (m_st == 2); nst = 0; ng = 0;
            end
        end
        if (vr && nst == 1 && ng >= 4) nst = 2;
        if (vr && m_st == 2 && nst == 2 && free_v != 254) begin err = 1; nst = 0; end
        m_since = hr ? 0 : m_since + 1;
        m_hs_prev = hs; m_vs_prev = vs;
        m_h = nh; m_v = nv; m_st = nst; m_good = ng;
        m_locked = (nst == 2);
        m_disp = m_locked && nh < H_DISPLAY && nv < V_DISPLAY;
        m_fs = m_locked && nh == 0 && nv == 0;
        m_err = err;
    endtask

    task automatic cycle();
        @(negedge clk);
        check("hpos", hpos, m_h);
        check("vpos", vpos, m_v);
        check("display_on", display_on, m_disp);
        check("locked", locked, m_locked);
        check("frame_start", frame_start, m_fs);
        check("sync_err", sync_err, m_err);
        if (aligned && m_locked) begin
            check("hpos_delay1", hpos, exp_h);
            check("vpos_delay1", vpos, exp_v);
        end
        if (m_locked && m_v == 10 && m_h == 255) check("disp_h255", display_on, 1);
        if (m_locked && m_v == 10 && m_h == 256) check("disp_h256", display_on, 0);
        if (m_locked && m_v == 10 && m_h == 0)   check("disp_h0", display_on, 1);
        reset = rst_n_ctl;
        hsync = hs_reg & ~hold;
        vsync = vs_reg | inj;
        model_step(reset, hsync, vsync);
        exp_h = src_h;
        exp_v = src_v;
        hs_reg = (src_h >= 263 && src_h <= 285);
        vs_reg = (src_v >= 254 && src_v <= 256);
        src_h++;
        if (src_h >= cur_len) begin
            src_h = 0;
            cur_len = H_TOTAL;
            src_v = (src_v + 1) % V_TOTAL;
        end
    endtask

    task automatic wait_locked(input string name, input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            cycle();
            if (locked === 1'b1) break;
        end
        if (n >= bound) check(name, 0, 1);
    endtask

    initial begin
        int errs;
        int n;
        reset = 1'b0; hsync = 1'b0; vsync = 1'b0;
        rst_n_ctl = 0; hold = 0; inj = 0; aligned = 1; hold_left = 0;
        src_h = 0; src_v = 236; cur_len = H_TOTAL; hs_reg = 0; vs_reg = 0;
        exp_h = 0; exp_v = 0;
        model_step(1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        rst_n_ctl = 1;

        // First lock lands on the vsync edge: vpos loaded, hpos one past line start.
        wait_locked("lock_timeout", 8000);
        check("lock_hpos", hpos, 1);
        check("lock_vpos", vpos, 254);

        for (n = 0; n < 4000 && frame_start !== 1'b1; n++) cycle();
        check("frame_start_seen", frame_start, 1);
        check("frame_start_hpos", hpos, 0);
        check("frame_start_vpos", vpos, 0);
        for (n = 0; n < 4000 && m_v != 11; n++) cycle();
        aligned = 0;

        // Stretched line while locked.
        cur_len = H_TOTAL + 1;
        errs = 0;
        repeat (800) begin cycle(); errs += int'(sync_err); end
        check("stretch_err_pulses", errs, 1);
        check("stretch_unlocked", locked, 0);
        src_v = 246;
        wait_locked("relock1_timeout", 6000);

        // hsync held low while locked: single timeout error.
        hold = 1;
        errs = 0;
        repeat (900) begin cycle(); errs += int'(sync_err); end
        check("timeout_err_pulses", errs, 1);
        check("timeout_unlocked", locked, 0);
        hold = 0;
        src_v = 246;
        wait_locked("relock2_timeout", 6000);

        // Unexpected vsync edge while locked.
        repeat (1000) cycle();
        inj = 1;
        cycle();
        inj = 0;
        cycle();
        check("inj_vpos", vpos, 254);
        check("inj_err", sync_err, 1);
        check("inj_unlocked", locked, 0);

        // One-clock reset mid-frame with hsync already high across release.
        for (n = 0; n < 400 && !(hsync === 1'b1 && exp_h >= 266 && exp_h <= 280); n++) cycle();
        rst_n_ctl = 0;
        cycle();
        rst_n_ctl = 1;
        cycle();
        check("rst_hpos", hpos, 0);
        check("rst_vpos", vpos, 0);
        check("rst_flags", {display_on, locked, frame_start, sync_err}, 0);
        cycle();
        check("rst_no_hs_edge", hpos, 1);

        // Randomized disturbances against the model.
        repeat (30000) begin
            if ($urandom_range(0, 2999) == 0) cur_len = H_TOTAL - 1 + $urandom_range(0, 2);
            if ($urandom_range(0, 1999) == 0) src_v = $urandom_range(230, 261);
            if (hold_left == 0 && $urandom_range(0, 4999) == 0) hold_left = $urandom_range(100, 800);
            hold = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            inj = ($urandom_range(0, 3999) == 0);
            rst_n_ctl = ($urandom_range(0, 9999) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
